// File: rtl/bitonic_sort_ctrl.sv
// bitonic_sort_ctrl: sequential 8-entry bitonic sorter.
// Collects 8 words on a valid/ready input stream, runs the six
// compare-exchange layers of the 8-input bitonic network on a
// 4-comparator datapath (one layer per clock), then streams the
// sorted words out on a valid/ready output stream.
// Optional build macro BITONIC_DIR_EN adds input dir_desc, sampled on
// the first beat of each batch; when set, the batch is sorted with the
// largest word first.
module bitonic_sort_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
`ifdef BITONIC_DIR_EN
   ,
   input  logic              dir_desc
`endif
);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} stateT;

   stateT             r_state;
   logic [2:0]        r_ldCnt;
   logic [2:0]        r_rdCnt;
   logic [2:0]        r_layer;
   logic [DATA_W-1:0] r_buf [8];
   logic              r_inReady;
   logic              r_outValid;
   logic [DATA_W-1:0] r_outData;
   logic              r_busy;

   logic [DATA_W-1:0] w_sortBuf [8];
   logic [2:0]        w_rdNext;
   logic              w_invert;

`ifdef BITONIC_DIR_EN
   logic              r_dirQ;
   assign w_invert = r_dirQ;
`else
   assign w_invert = 1'b0;
`endif

   assign w_rdNext  = r_rdCnt + 3'd1;
   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign busy      = r_busy;

   // One comparator: returns {new buf[i], new buf[j]}; ascending puts the
   // minimum in slot i, descending the maximum. Equal words are untouched.
   function automatic logic [2*DATA_W-1:0] compareExchange(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic              desc
   );
      logic doSwap;
      doSwap = desc ? (a < b) : (a > b);
      return doSwap ? {b, a} : {a, b};
   endfunction

   // Next buffer contents for the current layer; all four comparators read the same registered buffer.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w_sortBuf[k] = r_buf[k];
      end
      case (r_layer)
         3'd0: begin
            {w_sortBuf[0], w_sortBuf[1]} = compareExchange(r_buf[0], r_buf[1],  w_invert);
            {w_sortBuf[2], w_sortBuf[3]} = compareExchange(r_buf[2], r_buf[3], ~w_invert);
            {w_sortBuf[4], w_sortBuf[5]} = compareExchange(r_buf[4], r_buf[5],  w_invert);
            {w_sortBuf[6], w_sortBuf[7]} = compareExchange(r_buf[6], r_buf[7], ~w_invert);
         end
         3'd1: begin
            {w_sortBuf[0], w_sortBuf[2]} = compareExchange(r_buf[0], r_buf[2],  w_invert);
            {w_sortBuf[1], w_sortBuf[3]} = compareExchange(r_buf[1], r_buf[3],  w_invert);
            {w_sortBuf[4], w_sortBuf[6]} = compareExchange(r_buf[4], r_buf[6], ~w_invert);
            {w_sortBuf[5], w_sortBuf[7]} = compareExchange(r_buf[5], r_buf[7], ~w_invert);
         end
         3'd2: begin
            {w_sortBuf[0], w_sortBuf[1]} = compareExchange(r_buf[0], r_buf[1],  w_invert);
            {w_sortBuf[2], w_sortBuf[3]} = compareExchange(r_buf[2], r_buf[3],  w_invert);
            {w_sortBuf[4], w_sortBuf[5]} = compareExchange(r_buf[4], r_buf[5], ~w_invert);
            {w_sortBuf[6], w_sortBuf[7]} = compareExchange(r_buf[6], r_buf[7], ~w_invert);
         end
         3'd3: begin
            {w_sortBuf[0], w_sortBuf[4]} = compareExchange(r_buf[0], r_buf[4], w_invert);
            {w_sortBuf[1], w_sortBuf[5]} = compareExchange(r_buf[1], r_buf[5], w_invert);
            {w_sortBuf[2], w_sortBuf[6]} = compareExchange(r_buf[2], r_buf[6], w_invert);
            {w_sortBuf[3], w_sortBuf[7]} = compareExchange(r_buf[3], r_buf[7], w_invert);
         end
         3'd4: begin
            {w_sortBuf[0], w_sortBuf[2]} = compareExchange(r_buf[0], r_buf[2], w_invert);
            {w_sortBuf[1], w_sortBuf[3]} = compareExchange(r_buf[1], r_buf[3], w_invert);
            {w_sortBuf[4], w_sortBuf[6]} = compareExchange(r_buf[4], r_buf[6], w_invert);
            {w_sortBuf[5], w_sortBuf[7]} = compareExchange(r_buf[5], r_buf[7], w_invert);
         end
         3'd5: begin
            {w_sortBuf[0], w_sortBuf[1]} = compareExchange(r_buf[0], r_buf[1], w_invert);
            {w_sortBuf[2], w_sortBuf[3]} = compareExchange(r_buf[2], r_buf[3], w_invert);
            {w_sortBuf[4], w_sortBuf[5]} = compareExchange(r_buf[4], r_buf[5], w_invert);
            {w_sortBuf[6], w_sortBuf[7]} = compareExchange(r_buf[6], r_buf[7], w_invert);
         end
         default: ;
      endcase
   end

   // Batch FSM: load eight words, apply six layers, drain eight words; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= LOAD;
         r_ldCnt    <= 3'd0;
         r_rdCnt    <= 3'd0;
         r_layer    <= 3'd0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_busy     <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            r_buf[k] <= '0;
         end
`ifdef BITONIC_DIR_EN
         r_dirQ     <= 1'b0;
`endif
      end else begin
         case (r_state)
            LOAD: begin
               if (in_valid) begin
                  r_buf[r_ldCnt] <= in_data;
                  r_busy         <= 1'b1;
                  r_ldCnt        <= r_ldCnt + 3'd1;
`ifdef BITONIC_DIR_EN
                  if (r_ldCnt == 3'd0) begin
                     r_dirQ <= dir_desc;
                  end
`endif
                  if (r_ldCnt == 3'd7) begin
                     r_state   <= SORT;
                     r_layer   <= 3'd0;
                     r_inReady <= 1'b0;
                  end
               end
            end
            SORT: begin
               for (int k = 0; k < 8; k++) begin
                  r_buf[k] <= w_sortBuf[k];
               end
               if (r_layer == 3'd5) begin
                  r_state    <= DRAIN;
                  r_rdCnt    <= 3'd0;
                  r_outValid <= 1'b1;
                  r_outData  <= w_sortBuf[0];
               end else begin
                  r_layer <= r_layer + 3'd1;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (r_rdCnt == 3'd7) begin
                     r_state    <= LOAD;
                     r_rdCnt    <= 3'd0;
                     r_ldCnt    <= 3'd0;
                     r_outValid <= 1'b0;
                     r_outData  <= '0;
                     r_inReady  <= 1'b1;
                     r_busy     <= 1'b0;
                  end else begin
                     r_rdCnt   <= w_rdNext;
                     r_outData <= r_buf[w_rdNext];
                  end
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// tb_bitonic_sort_ctrl: self-checking bench for bitonic_sort_ctrl.
// Fixed vectors from a table, random batches checked against a sorted
// queue, and hand-written sequences for reset during sorting.
module tb_bitonic_sort_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       busy;
`ifdef BITONIC_DIR_EN
   logic       dirDesc = 1'b0;
   logic       descSel = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0][7:0] words;
      logic [7:0][7:0] expWords;
      int              gapAt;
      int              gapLen;
      int              readyMode;
      logic            holdValid;
   } vecT;

   vecT        tbl [4];
   logic [7:0] wIn [8];
   logic [7:0] wExp [8];
   logic [7:0] got [8];
   logic [7:0] model [$];

   bitonic_sort_ctrl #(.DATA_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .busy(busy)
`ifdef BITONIC_DIR_EN
      ,
      .dir_desc(dirDesc)
`endif
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   // Runs one full batch; must be entered just after a rising edge with the DUT idle.
   // readyMode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
   task automatic applyStimulus(input logic [7:0] w [8], input int gapAt, input int gapLen,
                                input int readyMode, input logic holdValid, input string tag,
                                output logic [7:0] res [8]);
      int idx = 0, nOut = 0, gapLeft = 0, lastIn = -1, firstOut = -1;
      int stallErr = 0, rdyErr = 0, busyErr = 0;
      logic prevStall = 1'b0;
      logic [7:0] prevData = 8'd0;
      for (int k = 0; k < 8; k++) res[k] = 8'd0;
      for (int cyc = 0; cyc < 400 && nOut < 8; cyc++) begin
         if (idx < 8) begin
            if (gapLeft > 0) begin
               in_valid = 1'b0;
               gapLeft--;
            end else begin
               in_valid = 1'b1;
               in_data  = w[idx];
            end
`ifdef BITONIC_DIR_EN
            dirDesc = (idx == 0) ? descSel : !descSel;
`endif
         end else begin
            in_valid = holdValid;
            in_data  = 8'($urandom);
         end
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (idx == 8 && in_ready) rdyErr++;
         if (idx > 0 && busy !== 1'b1) busyErr++;
         if (prevStall && (out_valid !== 1'b1 || out_data !== prevData)) stallErr++;
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         if (out_valid && firstOut < 0) firstOut = cyc;
         if (out_valid && out_ready) begin
            res[nOut] = out_data;
            nOut++;
         end
         if (idx < 8 && in_valid && in_ready) begin
            idx++;
            if (idx == 8) lastIn = cyc;
            if (idx == gapAt) gapLeft = gapLen;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput({tag, " words drained"}, nOut, 8);
      checkOutput({tag, " first out_valid cycles after last input"}, firstOut - lastIn, 7);
      checkOutput({tag, " stall hold errors"}, stallErr, 0);
      checkOutput({tag, " in_ready high while busy"}, rdyErr, 0);
      checkOutput({tag, " busy low mid batch"}, busyErr, 0);
      @(negedge clk);
      checkOutput({tag, " idle {in_ready,out_valid,busy}"}, {in_ready, out_valid, busy}, 3'b100);
      @(posedge clk);
      #1;
   endtask

   // Reference model: the batch sorted as a plain queue
   task automatic buildModel(input logic [7:0] w [8], input logic desc);
      model.delete();
      for (int k = 0; k < 8; k++) model.push_back(w[k]);
      if (desc) model.rsort();
      else model.sort();
   endtask

   task automatic compareWords(input string tag, input logic [7:0] res [8]);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("%s word %0d", tag, k), res[k], model[k]);
      end
   endtask

   // Main test sequence
   initial begin
      logic [7:0] tmp [8];
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      tmp = '{8, 7, 6, 5, 4, 3, 2, 1};
      for (int k = 0; k < 8; k++) tbl[0].words[k] = tmp[k];
      tmp = '{1, 2, 3, 4, 5, 6, 7, 8};
      for (int k = 0; k < 8; k++) tbl[0].expWords[k] = tmp[k];
      tbl[0].gapAt = 0; tbl[0].gapLen = 0; tbl[0].readyMode = 0; tbl[0].holdValid = 1'b0;
      tmp = '{5, 5, 0, 255, 5, 0, 255, 5};
      for (int k = 0; k < 8; k++) tbl[1].words[k] = tmp[k];
      tmp = '{0, 0, 5, 5, 5, 5, 255, 255};
      for (int k = 0; k < 8; k++) tbl[1].expWords[k] = tmp[k];
      tbl[1].gapAt = 0; tbl[1].gapLen = 0; tbl[1].readyMode = 0; tbl[1].holdValid = 1'b0;
      tmp = '{3, 1, 4, 1, 5, 9, 2, 6};
      for (int k = 0; k < 8; k++) tbl[2].words[k] = tmp[k];
      tmp = '{1, 1, 2, 3, 4, 5, 6, 9};
      for (int k = 0; k < 8; k++) tbl[2].expWords[k] = tmp[k];
      tbl[2].gapAt = 0; tbl[2].gapLen = 0; tbl[2].readyMode = 1; tbl[2].holdValid = 1'b0;
      tmp = '{200, 17, 99, 3, 150, 42, 77, 1};
      for (int k = 0; k < 8; k++) tbl[3].words[k] = tmp[k];
      tmp = '{1, 3, 17, 42, 77, 99, 150, 200};
      for (int k = 0; k < 8; k++) tbl[3].expWords[k] = tmp[k];
      tbl[3].gapAt = 4; tbl[3].gapLen = 3; tbl[3].readyMode = 1; tbl[3].holdValid = 1'b1;

      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 8; k++) begin
            wIn[k]  = tbl[i].words[k];
            wExp[k] = tbl[i].expWords[k];
         end
         applyStimulus(wIn, tbl[i].gapAt, tbl[i].gapLen, tbl[i].readyMode, tbl[i].holdValid,
                       $sformatf("vec%0d", i), got);
         for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("vec%0d word %0d", i, k), got[k], wExp[k]);
         end
      end

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 8; k++) wIn[k] = (r == 0) ? 8'(k % 3) : 8'($urandom);
         buildModel(wIn, 1'b0);
         applyStimulus(wIn, 1 + (r % 7), r % 3, 2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r), got);
         compareWords($sformatf("rand%0d", r), got);
      end

      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 8'(200 + k);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre-reset busy", busy, 1);
      checkOutput("pre-reset in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset in_ready", in_ready, 1);
      checkOutput("async reset out_valid", out_valid, 0);
      checkOutput("async reset out_data", out_data, 0);
      checkOutput("async reset busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) wIn[k] = 8'(10 * (k + 1));
      buildModel(wIn, 1'b0);
      applyStimulus(wIn, 0, 0, 0, 1'b0, "post-reset", got);
      compareWords("post-reset", got);

`ifdef BITONIC_DIR_EN
      descSel = 1'b1;
      for (int k = 0; k < 8; k++) wIn[k] = 8'(k + 1);
      buildModel(wIn, 1'b1);
      applyStimulus(wIn, 0, 0, 0, 1'b0, "desc", got);
      compareWords("desc", got);
      descSel = 1'b0;
      for (int k = 0; k < 8; k++) wIn[k] = 8'($urandom);
      buildModel(wIn, 1'b0);
      applyStimulus(wIn, 0, 0, 2, 1'b0, "asc-after-desc", got);
      compareWords("asc-after-desc", got);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
